// File: rtl/fir_sekwencer.sv
// rtl/fir_sekwencer.sv - FIR control sequencer and MAC engine driving the sample shift register
module fir_sekwencer #(
  parameter int TAPS      = 32,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int N_W       = 14,
  parameter int SHIFT_OUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    ile_probek,
  output logic              busy,
  output logic              done,
  output logic [N_W-1:0]    in_adres,
  output logic              shift_reset,
  output logic              shift_new,
  output logic [4:0]        shift_adres,
  input  logic [DATA_W-1:0] shift_data,
  output logic [4:0]        coef_adres,
  input  logic [DATA_W-1:0] coef_data,
  output logic              wyn_we,
  output logic [N_W-1:0]    wyn_adres,
  output logic [DATA_W-1:0] wyn_data
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

  // Output clamp limits expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD,
    SHIFT,
    MAC,
    DRAIN,
    WR,
    FIN
  } state_t;

  state_t state, state_next;

  logic [N_W-1:0] count;
  logic [N_W-1:0] n;
  logic [N_W-1:0] n_next;
  logic [N_W-1:0] n_inc;
  logic [4:0]     tap_next;
  logic           drain_cnt;

  // Pipeline: v1 marks cycles where RAM/shift-register data is valid, v2 marks a valid product
  logic                     v1;
  logic                     v2;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [DATA_W-1:0]        sat_val;

  assign n_inc = n + N_W'(1);

  // State register plus run bookkeeping (latched count, sample index, drain counter)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      n         <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      n         <= n_next;
      drain_cnt <= (state == DRAIN);
      if (state == IDLE && start) begin
        count <= ile_probek;
      end
    end
  end

  // Next-state logic with next sample index and next tap address
  always_comb begin
    state_next = state;
    n_next     = n;
    tap_next   = shift_adres;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLR;
          n_next     = '0;
        end
      end
      CLR: begin
        state_next = (count == '0) ? FIN : RD;
      end
      RD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        state_next = MAC;
        tap_next   = '0;
      end
      MAC: begin
        if (shift_adres == LAST_TAP) begin
          state_next = DRAIN;
        end else begin
          tap_next = shift_adres + 5'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_next = WR;
        end
      end
      WR: begin
        n_next     = n_inc;
        state_next = (n_inc < count) ? RD : FIN;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulator update, arithmetic shift and output clamp for the sample being finished
  always_comb begin
    acc_next = acc;
    if (state == SHIFT) begin
      acc_next = '0;
    end else if (v2) begin
      acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
    acc_shr = acc_next >>> SHIFT_OUT;
    sat_val = acc_shr[DATA_W-1:0];
    if (acc_shr > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (acc_shr < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  // Multiply-accumulate pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      prod <= '0;
      acc  <= '0;
    end else begin
      v1  <= (state == MAC);
      v2  <= v1;
      acc <= acc_next;
      if (v1) begin
        prod <= $signed(shift_data) * $signed(coef_data);
      end
    end
  end

  // Registered outputs, decoded from the state being entered so they align with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      shift_reset <= 1'b0;
      shift_new   <= 1'b0;
      wyn_we      <= 1'b0;
      in_adres    <= '0;
      shift_adres <= '0;
      coef_adres  <= '0;
      wyn_adres   <= '0;
      wyn_data    <= '0;
    end else begin
      busy        <= (state_next != IDLE) && (state_next != FIN);
      done        <= (state_next == FIN);
      shift_reset <= (state_next == CLR);
      shift_new   <= (state_next == SHIFT);
      wyn_we      <= (state_next == WR);
      if (state_next == RD) begin
        in_adres <= n_next;
      end
      if (state_next == MAC) begin
        shift_adres <= tap_next;
        coef_adres  <= tap_next;
      end
      if (state_next == WR) begin
        wyn_adres <= n;
        wyn_data  <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_fir_sekwencer.sv
// tb/tb_fir_sekwencer.sv - directed self-checking bench for fir_sekwencer
module tb_fir_sekwencer;

  localparam int DATA_W = 16;
  localparam int N_W    = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N_W-1:0]    ile_probek = '0;
  logic              busy;
  logic              done;
  logic [N_W-1:0]    in_adres;
  logic              shift_reset;
  logic              shift_new;
  logic [4:0]        shift_adres;
  logic [DATA_W-1:0] shift_data;
  logic [4:0]        coef_adres;
  logic [DATA_W-1:0] coef_data;
  logic              wyn_we;
  logic [N_W-1:0]    wyn_adres;
  logic [DATA_W-1:0] wyn_data;

  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_mem   [0:15];
  logic [DATA_W-1:0] coef_mem [0:31];
  logic [DATA_W-1:0] sr       [0:31];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Monitor-owned logs
  int wr_cyc[$];
  int wr_adr[$];
  int wr_dat[$];
  int sn_cyc[$];
  int sr_cyc[$];
  int done_cyc[$];
  int busy_rise[$];
  int busy_fall[$];
  int addr_err = 0;
  int mac_k    = 0;
  bit mac_on   = 1'b0;
  int sn_num   = 0;
  bit busy_q   = 1'b0;

  fir_sekwencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ile_probek  (ile_probek),
    .busy        (busy),
    .done        (done),
    .in_adres    (in_adres),
    .shift_reset (shift_reset),
    .shift_new   (shift_new),
    .shift_adres (shift_adres),
    .shift_data  (shift_data),
    .coef_adres  (coef_adres),
    .coef_data   (coef_data),
    .wyn_we      (wyn_we),
    .wyn_adres   (wyn_adres),
    .wyn_data    (wyn_data)
  );

  always #5 clk = ~clk;

  // Cycle counter, 1-cycle-latency RAMs and the sample shift register
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    in_data    <= in_mem[in_adres[3:0]];
    coef_data  <= coef_mem[coef_adres];
    shift_data <= sr[shift_adres];
    if (shift_reset) begin
      for (int i = 0; i < 32; i++) sr[i] <= '0;
    end else if (shift_new) begin
      for (int i = 31; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= in_data;
    end
  end

  // Event logger and address-sweep watcher, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mac_on = 1'b0;
      busy_q = 1'b0;
    end else begin
      if (busy && !busy_q) busy_rise.push_back(cyc);
      if (!busy && busy_q) busy_fall.push_back(cyc - 1);
      busy_q = busy;
      if (wyn_we) begin
        wr_cyc.push_back(cyc);
        wr_adr.push_back(int'(wyn_adres));
        wr_dat.push_back(int'($signed(wyn_data)));
      end
      if (done) done_cyc.push_back(cyc);
      if (shift_reset) begin
        sr_cyc.push_back(cyc);
        sn_num = 0;
      end
      if (mac_on) begin
        if (int'(shift_adres) != mac_k || int'(coef_adres) != mac_k) addr_err++;
        mac_k++;
        if (mac_k == 32) mac_on = 1'b0;
      end
      if (shift_new) begin
        sn_cyc.push_back(cyc);
        if (int'(in_adres) != sn_num) addr_err++;
        sn_num++;
        mac_on = 1'b1;
        mac_k  = 0;
      end
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 16; i++) in_mem[i] = '0;
    for (int i = 0; i < 32; i++) coef_mem[i] = '0;
    in_mem[0]   = 16'd16384;
    coef_mem[0] = 16'(1000);
    coef_mem[1] = 16'(2000);
    coef_mem[2] = 16'(-3000);
    coef_mem[3] = 16'(4000);
  endtask

  task automatic wait_done(input int nd0);
    int t;
    t = 0;
    while (done_cyc.size() == nd0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check_val("done_seen", done_cyc.size() - nd0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_job(input int cnt, input bit poke, output int s);
    int nd0;
    nd0 = done_cyc.size();
    @(negedge clk);
    ile_probek = N_W'(cnt);
    start      = 1'b1;
    s          = cyc;
    @(negedge clk);
    start      = 1'b0;
    ile_probek = 14'h2aaa;
    if (poke) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      repeat (5) @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(nd0);
  endtask

  task automatic check_timing3(input string tg, input int s, input int w0, input int n0,
                               input int r0, input int d0, input int b0);
    check_val({tg, "_wr_count"}, wr_cyc.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      check_val({tg, "_wr_cycle"}, wr_cyc[w0+i] - s, 38 + 37 * i);
      check_val({tg, "_shift_new_cycle"}, sn_cyc[n0+i] - s, 3 + 37 * i);
    end
    check_val({tg, "_shift_new_count"}, sn_cyc.size() - n0, 3);
    check_val({tg, "_shift_reset_count"}, sr_cyc.size() - r0, 1);
    check_val({tg, "_shift_reset_cycle"}, sr_cyc[r0] - s, 1);
    check_val({tg, "_done_count"}, done_cyc.size() - d0, 1);
    check_val({tg, "_done_cycle"}, done_cyc[d0] - s, 113);
    check_val({tg, "_busy_rise"}, busy_rise[b0] - s, 1);
    check_val({tg, "_busy_fall"}, busy_fall[b0] - s, 112);
  endtask

  initial begin
    int s, w0, n0, r0, d0, b0, a0;
    int exp_imp [4];
    exp_imp = '{500, 1000, -1500, 2000};
    load_impulse();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_outputs",
              {done, wyn_we, shift_new, shift_reset, in_adres, shift_adres, coef_adres,
               wyn_adres, wyn_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Impulse response
    w0 = wr_cyc.size(); a0 = addr_err;
    run_job(4, 1'b0, s);
    check_val("imp_wr_count", wr_cyc.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check_val("imp_data", wr_dat[w0+i], exp_imp[i]);
      check_val("imp_adres", wr_adr[w0+i], i);
    end
    check_val("imp_addr_sweep", addr_err - a0, 0);

    // Timing for three samples
    w0 = wr_cyc.size(); n0 = sn_cyc.size(); r0 = sr_cyc.size();
    d0 = done_cyc.size(); b0 = busy_rise.size(); a0 = addr_err;
    run_job(3, 1'b0, s);
    check_timing3("tim", s, w0, n0, r0, d0, b0);
    check_val("tim_addr_sweep", addr_err - a0, 0);

    // Saturation, positive then negative
    for (int i = 0; i < 16; i++) in_mem[i] = 16'(32767);
    for (int i = 0; i < 32; i++) coef_mem[i] = 16'(32767);
    w0 = wr_cyc.size();
    run_job(2, 1'b0, s);
    check_val("sat_pos_count", wr_cyc.size() - w0, 2);
    check_val("sat_pos_0", wr_dat[w0], 32766);
    check_val("sat_pos_1", wr_dat[w0+1], 32767);
    for (int i = 0; i < 16; i++) in_mem[i] = 16'h8000;
    w0 = wr_cyc.size();
    run_job(2, 1'b0, s);
    check_val("sat_neg_count", wr_cyc.size() - w0, 2);
    check_val("sat_neg_0", wr_dat[w0], -32767);
    check_val("sat_neg_1", wr_dat[w0+1], -32768);

    // Zero-length run
    load_impulse();
    w0 = wr_cyc.size(); n0 = sn_cyc.size(); r0 = sr_cyc.size(); d0 = done_cyc.size();
    b0 = busy_rise.size();
    run_job(0, 1'b0, s);
    check_val("zero_wr_count", wr_cyc.size() - w0, 0);
    check_val("zero_shift_new_count", sn_cyc.size() - n0, 0);
    check_val("zero_shift_reset_cycle", sr_cyc[r0] - s, 1);
    check_val("zero_done_cycle", done_cyc[d0] - s, 2);
    check_val("zero_busy_fall", busy_fall[b0] - s, 1);

    // Start pulses while busy are ignored
    w0 = wr_cyc.size(); n0 = sn_cyc.size(); r0 = sr_cyc.size();
    d0 = done_cyc.size(); b0 = busy_rise.size();
    run_job(3, 1'b1, s);
    check_timing3("poke", s, w0, n0, r0, d0, b0);
    for (int i = 0; i < 3; i++) check_val("poke_data", wr_dat[w0+i], exp_imp[i]);

    // Reset during the MAC phase of the second sample
    w0 = wr_cyc.size(); d0 = done_cyc.size();
    @(negedge clk);
    ile_probek = 14'd3;
    start      = 1'b1;
    s          = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_busy", busy, 0);
    check_val("abort_outputs",
              {done, wyn_we, shift_new, shift_reset, in_adres, shift_adres, coef_adres,
               wyn_adres, wyn_data}, 0);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check_val("abort_no_done", done_cyc.size() - d0, 0);
    check_val("abort_wr_count", wr_cyc.size() - w0, 1);

    // Clean rerun after the abort
    w0 = wr_cyc.size(); a0 = addr_err;
    run_job(4, 1'b0, s);
    check_val("rerun_wr_count", wr_cyc.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check_val("rerun_data", wr_dat[w0+i], exp_imp[i]);
      check_val("rerun_adres", wr_adr[w0+i], i);
    end
    check_val("rerun_addr_sweep", addr_err - a0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
